// File: rtl/nyan_audio_sequencer.sv
// Song-table sequencer with melody and bass square voices and decaying envelopes.
// Produces one 7-bit mixed sample per scanline strobe for the downstream PWM stage.
module nyan_audio_sequencer #(
    parameter int          SONG_LEN         = 288,
    parameter int          TICKS_PER_STEP   = 6,
    parameter int          MEL_DECAY_SHIFT  = 3,
    parameter int          BASS_DECAY_SHIFT = 2,
    parameter logic [63:0] NOTE_INC         = 64'h8E867F77716A645F
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        sample_stb,
    input  logic        tick_stb,
    output logic [8:0]  song_addr,
    input  logic [11:0] song_data,
    output logic [8:0]  song_pos,
    output logic        beat_stb,
    output logic [6:0]  audio_sample
);

    localparam logic [8:0] POS_LAST  = 9'(SONG_LEN - 1);
    localparam logic [7:0] TICK_LAST = 8'(TICKS_PER_STEP - 1);
    localparam logic [5:0] VOL_MAX   = 6'd63;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        LATCH = 2'd2
    } state_t;

    state_t state;
    state_t state_next;

    logic [7:0]  tick_ctr;
    logic        pending_tick;
    logic        init_fetch;

    logic [2:0]  mel_note;
    logic [1:0]  mel_oct;
    logic [2:0]  bass_note;
    logic [1:0]  bass_oct;
    logic [5:0]  mel_vol;
    logic [5:0]  bass_vol;
    logic [12:0] mel_pha;
    logic [15:0] bass_pha;

    // Song word fields
    logic        rom_mel_trig;
    logic [1:0]  rom_mel_oct;
    logic [2:0]  rom_mel_note;
    logic        rom_bass_trig;
    logic [1:0]  rom_bass_oct;
    logic [2:0]  rom_bass_note;

    assign rom_mel_trig  = song_data[11];
    assign rom_mel_oct   = song_data[10:9];
    assign rom_mel_note  = song_data[8:6];
    assign rom_bass_trig = song_data[5];
    assign rom_bass_oct  = song_data[4:3];
    assign rom_bass_note = song_data[2:0];

    logic        do_tick;
    logic        step_adv;
    logic [8:0]  pos_next;
    logic [7:0]  mel_inc;
    logic [7:0]  bass_inc;
    logic [12:0] mel_sum;
    logic [15:0] bass_sum;
    logic        mel_bit;
    logic        bass_bit;
    logic [6:0]  mix;
    logic [5:0]  mel_vol_decayed;
    logic [5:0]  bass_vol_decayed;

    // Next-state and datapath control
    always_comb begin
        state_next = state;
        do_tick    = (state == IDLE) && (tick_stb || pending_tick);
        step_adv   = do_tick && (tick_ctr == TICK_LAST);
        pos_next   = (song_pos == POS_LAST) ? 9'd0 : song_pos + 9'd1;

        case (state)
            IDLE:    if (step_adv) state_next = FETCH;
            FETCH:   state_next = LATCH;
            LATCH:   state_next = IDLE;
            default: state_next = FETCH;
        endcase
    end

    // Oscillator, envelope and mix arithmetic
    always_comb begin
        mel_inc  = NOTE_INC[{mel_note, 3'b000} +: 8];
        bass_inc = NOTE_INC[{bass_note, 3'b000} +: 8];
        mel_sum  = mel_pha + {5'd0, mel_inc};
        bass_sum = bass_pha + {8'd0, bass_inc};

        case (mel_oct)
            2'd2:    mel_bit = mel_sum[10];
            2'd1:    mel_bit = mel_sum[11];
            default: mel_bit = mel_sum[12];
        endcase

        case (bass_oct)
            2'd3:    bass_bit = bass_sum[12];
            2'd2:    bass_bit = bass_sum[13];
            2'd1:    bass_bit = bass_sum[14];
            default: bass_bit = bass_sum[15];
        endcase

        mix = {1'b0, (mel_bit ? mel_vol : 6'd0)} + {1'b0, (bass_bit ? bass_vol : 6'd0)};

        mel_vol_decayed  = mel_vol - (mel_vol >> MEL_DECAY_SHIFT);
        bass_vol_decayed = bass_vol - (bass_vol >> BASS_DECAY_SHIFT);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= FETCH;
        end else begin
            state <= state_next;
        end
    end

    // Step position, tick counting and deferred ticks
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            song_pos     <= POS_LAST;
            song_addr    <= POS_LAST;
            tick_ctr     <= 8'd0;
            pending_tick <= 1'b0;
            init_fetch   <= 1'b1;
            beat_stb     <= 1'b0;
        end else begin
            // High during the LATCH cycle of every fetch except the post-reset one
            beat_stb <= (state == FETCH) && !init_fetch;

            if (state == LATCH) begin
                init_fetch <= 1'b0;
            end

            if (state != IDLE) begin
                if (tick_stb) begin
                    pending_tick <= 1'b1;
                end
            end else begin
                pending_tick <= 1'b0;
            end

            if (do_tick) begin
                if (step_adv) begin
                    tick_ctr  <= 8'd0;
                    song_pos  <= pos_next;
                    song_addr <= pos_next;
                end else begin
                    tick_ctr <= tick_ctr + 8'd1;
                end
            end
        end
    end

    // Note latch and envelopes
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mel_note  <= 3'd0;
            mel_oct   <= 2'd0;
            bass_note <= 3'd0;
            bass_oct  <= 2'd0;
            mel_vol   <= 6'd0;
            bass_vol  <= 6'd0;
        end else if (state == LATCH) begin
            mel_note  <= rom_mel_note;
            mel_oct   <= rom_mel_oct;
            bass_note <= rom_bass_note;
            bass_oct  <= rom_bass_oct;
            if (rom_mel_trig && !init_fetch) begin
                mel_vol <= VOL_MAX;
            end
            if (rom_bass_trig && !init_fetch) begin
                bass_vol <= VOL_MAX;
            end
        end else if (do_tick && !step_adv) begin
            mel_vol  <= mel_vol_decayed;
            bass_vol <= bass_vol_decayed;
        end
    end

    // Phases advance and the sample is taken from the post-add phase bits
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mel_pha      <= 13'd0;
            bass_pha     <= 16'd0;
            audio_sample <= 7'd0;
        end else if (sample_stb) begin
            mel_pha      <= mel_sum;
            bass_pha     <= bass_sum;
            audio_sample <= mix;
        end
    end

endmodule

// File: tb/tb_nyan_audio_sequencer.sv
// Directed bench for nyan_audio_sequencer: envelope/step table, song wrap,
// deferred ticks, reset mid-fetch and the melody oscillator/mix path.
module tb_nyan_audio_sequencer;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        sample_stb = 1'b0;
    logic        tick_stb = 1'b0;
    logic [8:0]  song_addr;
    logic [11:0] song_data = 12'd0;
    logic [8:0]  song_pos;
    logic        beat_stb;
    logic [6:0]  audio_sample;

    logic [11:0] rom [0:511];

    int checks = 0;
    int errors = 0;
    int beat_cnt = 0;
    int beat_base;

    typedef struct {
        logic exp_beat;
        int   exp_pos;
        int   exp_mel;
        int   exp_bass;
    } tick_vec_t;

    typedef struct {
        int exp_pha;
        int exp_audio;
    } strobe_vec_t;

    tick_vec_t   tvec [15];
    strobe_vec_t svec [16];

    nyan_audio_sequencer dut (
        .clk          (clk),
        .reset        (reset),
        .sample_stb   (sample_stb),
        .tick_stb     (tick_stb),
        .song_addr    (song_addr),
        .song_data    (song_data),
        .song_pos     (song_pos),
        .beat_stb     (beat_stb),
        .audio_sample (audio_sample)
    );

    always #5 clk = ~clk;

    // Synchronous ROM: data valid one cycle after the address
    always @(posedge clk) song_data <= rom[song_addr];

    always @(posedge clk) if (beat_stb) beat_cnt <= beat_cnt + 1;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick_stb = 1'b0;
        sample_stb = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic tick();
        @(negedge clk) tick_stb = 1'b1;
        @(negedge clk) tick_stb = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic tick_checked(input tick_vec_t v, input int idx);
        @(negedge clk) tick_stb = 1'b1;
        @(negedge clk) tick_stb = 1'b0;
        check($sformatf("t%0d_beat_c1", idx), int'(beat_stb), 0);
        @(negedge clk);
        check($sformatf("t%0d_beat_c2", idx), int'(beat_stb), int'(v.exp_beat));
        @(negedge clk);
        check($sformatf("t%0d_beat_c3", idx), int'(beat_stb), 0);
        check($sformatf("t%0d_pos", idx), int'(song_pos), v.exp_pos);
        check($sformatf("t%0d_addr", idx), int'(song_addr), v.exp_pos);
        check($sformatf("t%0d_mel_vol", idx), int'(dut.mel_vol), v.exp_mel);
        check($sformatf("t%0d_bass_vol", idx), int'(dut.bass_vol), v.exp_bass);
    endtask

    task automatic strobe();
        @(negedge clk) sample_stb = 1'b1;
        @(negedge clk) sample_stb = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 512; i++) rom[i] = 12'h000;
        rom[287] = 12'hFFF;   // triggers here must be ignored on the post-reset fetch
        rom[0]   = 12'h8C5;   // melody trigger only
        rom[1]   = 12'h820;   // melody and bass trigger

        tvec[0]  = '{1'b0, 287, 0, 0};
        tvec[1]  = '{1'b0, 287, 0, 0};
        tvec[2]  = '{1'b0, 287, 0, 0};
        tvec[3]  = '{1'b0, 287, 0, 0};
        tvec[4]  = '{1'b0, 287, 0, 0};
        tvec[5]  = '{1'b1, 0, 63, 0};
        tvec[6]  = '{1'b0, 0, 56, 0};
        tvec[7]  = '{1'b0, 0, 49, 0};
        tvec[8]  = '{1'b0, 0, 43, 0};
        tvec[9]  = '{1'b0, 0, 38, 0};
        tvec[10] = '{1'b0, 0, 34, 0};
        tvec[11] = '{1'b1, 1, 63, 63};
        tvec[12] = '{1'b0, 1, 56, 48};
        tvec[13] = '{1'b0, 1, 49, 36};
        tvec[14] = '{1'b0, 1, 43, 27};

        // Melody inc 0x5F = 95 per strobe at oct 2: bit 10 set once the phase reaches 1024
        svec[0]  = '{95,   0};
        svec[1]  = '{190,  0};
        svec[2]  = '{285,  0};
        svec[3]  = '{380,  0};
        svec[4]  = '{475,  0};
        svec[5]  = '{570,  0};
        svec[6]  = '{665,  0};
        svec[7]  = '{760,  0};
        svec[8]  = '{855,  0};
        svec[9]  = '{950,  0};
        svec[10] = '{1045, 63};
        svec[11] = '{1140, 63};
        svec[12] = '{1235, 63};
        svec[13] = '{1330, 63};
        svec[14] = '{1425, 63};
        svec[15] = '{1520, 63};

        // ---------------- Run A: reset, envelopes, wrap, deferred tick ----------------
        do_reset();
        check("rst_pos", int'(song_pos), 287);
        check("rst_addr", int'(song_addr), 287);
        check("rst_audio", int'(audio_sample), 0);
        check("rst_beat", int'(beat_stb), 0);
        @(negedge clk);
        check("init_latch_beat", int'(beat_stb), 0);
        @(negedge clk);
        check("init_idle_beat", int'(beat_stb), 0);
        check("init_mel_vol", int'(dut.mel_vol), 0);
        check("init_bass_vol", int'(dut.bass_vol), 0);
        check("init_beat_cnt", beat_cnt, 0);

        for (int i = 0; i < 15; i++) tick_checked(tvec[i], i + 1);

        // Align to the last tick of step 1, then walk the whole song once
        repeat (2) tick();
        for (int i = 1; i <= 288; i++) begin
            tick();
            check($sformatf("wrap_pos_%0d", i), int'(song_pos), (1 + i) % 288);
            check($sformatf("wrap_addr_%0d", i), int'(song_addr), (1 + i) % 288);
            repeat (5) tick();
        end

        // Tick held through FETCH and LATCH: FETCH tick deferred, LATCH tick dropped
        @(negedge clk) tick_stb = 1'b1;
        @(negedge clk);
        check("pend_pos", int'(song_pos), 2);
        @(negedge clk);
        check("pend_beat", int'(beat_stb), 1);
        @(negedge clk) tick_stb = 1'b0;
        check("pend_ctr_before", int'(dut.tick_ctr), 0);
        @(negedge clk);
        check("pend_ctr_after", int'(dut.tick_ctr), 1);
        repeat (4) tick();
        check("pend_pos_hold", int'(song_pos), 2);
        tick();
        check("pend_pos_adv", int'(song_pos), 3);

        // ---------------- Run B: reset mid-fetch, oscillator and mix ----------------
        rom[0] = 12'hC00;     // melody trigger, oct 2, note 0
        do_reset();
        repeat (3) @(negedge clk);
        repeat (5) tick();
        beat_base = beat_cnt;
        @(negedge clk) tick_stb = 1'b1;
        @(negedge clk) tick_stb = 1'b0;
        check("mid_fetch_pos", int'(song_pos), 0);
        reset = 1'b1;
        @(negedge clk);
        check("mid_rst_pos", int'(song_pos), 287);
        check("mid_rst_addr", int'(song_addr), 287);
        check("mid_rst_beat", int'(beat_stb), 0);
        @(negedge clk) reset = 1'b0;
        repeat (3) @(negedge clk);
        check("mid_rst_beat_cnt", beat_cnt, beat_base);
        check("mid_rst_mel_vol", int'(dut.mel_vol), 0);

        repeat (6) tick();
        check("b_pos", int'(song_pos), 0);
        check("b_mel_vol", int'(dut.mel_vol), 63);
        check("b_bass_vol", int'(dut.bass_vol), 0);
        check("b_beat_cnt", beat_cnt, beat_base + 1);

        for (int i = 0; i < 16; i++) begin
            strobe();
            check($sformatf("s%0d_pha", i + 1), int'(dut.mel_pha), svec[i].exp_pha);
            check($sformatf("s%0d_audio", i + 1), int'(audio_sample), svec[i].exp_audio);
        end
        repeat (3) @(negedge clk);
        check("audio_hold", int'(audio_sample), 63);

        // Same-cycle sample and tick: sample sees the pre-decay volume
        @(negedge clk) begin
            sample_stb = 1'b1;
            tick_stb = 1'b1;
        end
        @(negedge clk) begin
            sample_stb = 1'b0;
            tick_stb = 1'b0;
        end
        check("simul_audio", int'(audio_sample), 63);
        check("simul_mel_vol", int'(dut.mel_vol), 56);
        strobe();
        check("post_decay_audio", int'(audio_sample), 56);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
